// File: rtl/lap_recorder_pkg.sv
// Shared types and default sizes for the lap recorder: FSM encoding and
// BCD word geometry of the stopwatch count.
package lap_recorder_pkg;

  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 6;
  localparam int DEPTH_DEF  = 16;
  localparam int AW_DEF     = 4;
  localparam int DW_DEF     = BCD_W * BCD_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ      = 2'd2,
    ST_READ_WAIT = 2'd3
  } lap_state_e;

endpackage

// File: rtl/lap_recorder_key_sync.sv
// Two-flop synchronizer for a raw (already debounced) key, followed by a
// rising-edge detector producing a one-cycle pulse.
module key_sync_edge (
  input  logic clk_50Mhz,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);

  // [0],[1] synchronize; [2] remembers the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[1:0], key_i};
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/lap_recorder.sv
// Lap-time recorder: stores snapshots of the live BCD count into an external
// single-port RAM and replays them one at a time for the display stage.
module lap_recorder
  import lap_recorder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 2
) (
  input  logic          clk_50Mhz,
  input  logic          rst,
  input  logic          key_lap,
  input  logic          key_recall,
  input  logic          clr,
  input  logic [DW-1:0] dispbuf,
  input  logic [DW-1:0] ram_q,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic [DW-1:0] rec_disp,
  output logic          rec_valid,
  output logic [AW:0]   lap_count,
  output logic          full
);

  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);

  logic lap_ev, recall_ev;

  key_sync_edge u_sync_lap (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .key_i     (key_lap),
    .pulse_o   (lap_ev)
  );

  key_sync_edge u_sync_recall (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .key_i     (key_recall),
    .pulse_o   (recall_ev)
  );

  lap_state_e    state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          wren_q;
  logic [DW-1:0] rec_disp_q;
  logic          rec_valid_q;
  logic [AW:0]   cnt_q;
  logic          full_q;
  logic [AW:0]   ptr_q;
  logic [1:0]    wait_q;

  logic [AW:0]   cnt_d;
  logic [AW:0]   ptr_d;

  assign cnt_d = cnt_q + 1'b1;
  // Recall pointer walks 0..lap_count-1 and wraps
  assign ptr_d = (ptr_q + 1'b1 == cnt_q) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      rec_disp_q  <= '0;
      rec_valid_q <= 1'b0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      ptr_q       <= '0;
      wait_q      <= '0;
    end else if (clr) begin
      state_q     <= ST_IDLE;
      wren_q      <= 1'b0;
      rec_disp_q  <= '0;
      rec_valid_q <= 1'b0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      ptr_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A lap press always shadows a simultaneous recall press
          if (lap_ev) begin
            if (!full_q) begin
              data_q      <= dispbuf;
              addr_q      <= cnt_q[AW-1:0];
              wren_q      <= 1'b1;
              rec_valid_q <= 1'b0;
              state_q     <= ST_WRITE;
            end
          end else if (recall_ev && cnt_q != '0) begin
            addr_q  <= ptr_q[AW-1:0];
            wait_q  <= '0;
            state_q <= ST_READ_WAIT;
          end
        end
        ST_WRITE: begin
          wren_q  <= 1'b0;
          cnt_q   <= cnt_d;
          full_q  <= (cnt_d == DEPTH_C);
          state_q <= ST_IDLE;
        end
        ST_READ_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            rec_disp_q  <= ram_q;
            rec_valid_q <= 1'b1;
            ptr_q       <= ptr_d;
            state_q     <= ST_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr  = addr_q;
  assign ram_data  = data_q;
  // clr must suppress a write already under way in the same cycle
  assign ram_wren  = wren_q & ~clr;
  assign rec_disp  = rec_disp_q;
  assign rec_valid = rec_valid_q;
  assign lap_count = cnt_q;
  assign full      = full_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder with a behavioural RAM of read latency RD_LAT.
module tb_lap_recorder;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_lap, key_recall, clr;
  logic [23:0] dispbuf, ram_q, ram_data, rec_disp;
  logic [3:0]  ram_addr;
  logic        ram_wren, rec_valid, full;
  logic [4:0]  lap_count;

  int tests = 0;
  int fails = 0;

  logic [27:0] wq[$];
  logic [23:0] rq[$];

  lap_recorder #(.DEPTH(16), .AW(4), .DW(24), .RD_LAT(RD_LAT)) dut (
    .clk_50Mhz (clk),
    .rst       (rst),
    .key_lap   (key_lap),
    .key_recall(key_recall),
    .clr       (clr),
    .dispbuf   (dispbuf),
    .ram_q     (ram_q),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .rec_disp  (rec_disp),
    .rec_valid (rec_valid),
    .lap_count (lap_count),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address sampled at the edge after it is set, q registered
  logic [23:0] mem [16];
  logic [23:0] q_r;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    q_r = '0;
  end
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    q_r <= mem[ram_addr];
  end
  assign ram_q = q_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse and every new recalled value is matched to the queues
  logic        pv = 1'b0;
  logic [23:0] pd = '0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ram_wren) begin
        if (wq.size() == 0) check("unexpected_write", {4'h0, ram_addr, ram_data}, 32'hFFFF_FFFF);
        else begin
          logic [27:0] e;
          e = wq.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e[27:24]));
          check("wr_data", 32'(ram_data), 32'(e[23:0]));
        end
      end
      if (rec_valid && (!pv || rec_disp !== pd)) begin
        if (rq.size() == 0) check("unexpected_recall", 32'(rec_disp), 32'hFFFF_FFFF);
        else begin
          logic [23:0] r;
          r = rq.pop_front();
          check("rec_disp", 32'(rec_disp), 32'(r));
        end
      end
    end
    pv = rec_valid;
    pd = rec_disp;
  end

  task automatic press_lap(input logic [23:0] val, input bit exp_wr, input logic [3:0] exp_addr);
    @(negedge clk);
    dispbuf = val;
    key_lap = 1'b1;
    if (exp_wr) wq.push_back({exp_addr, val});
    repeat (2) @(negedge clk);
    check("lap_wren_early", 32'(ram_wren), 32'd0);
    @(negedge clk);
    check("lap_wren", 32'(ram_wren), 32'(exp_wr));
    key_lap = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_recall(input logic [3:0] exp_ptr, input logic [23:0] exp_val);
    @(negedge clk);
    key_recall = 1'b1;
    rq.push_back(exp_val);
    repeat (3) @(negedge clk);
    check("rcl_addr", 32'(ram_addr), 32'(exp_ptr));
    key_recall = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    check("rcl_valid", 32'(rec_valid), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; key_lap = 1'b0; key_recall = 1'b0; clr = 1'b0; dispbuf = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_data", 32'(ram_data), 0);
    check("rst_wren", 32'(ram_wren), 0);
    check("rst_rec_disp", 32'(rec_disp), 0);
    check("rst_rec_valid", 32'(rec_valid), 0);
    check("rst_lap_count", 32'(lap_count), 0);
    check("rst_full", 32'(full), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Three laps then four recalls with wrap
    press_lap(24'h000123, 1'b1, 4'd0);
    press_lap(24'h000456, 1'b1, 4'd1);
    press_lap(24'h001000, 1'b1, 4'd2);
    check("count_3", 32'(lap_count), 3);
    press_recall(4'd0, 24'h000123);
    press_recall(4'd1, 24'h000456);
    press_recall(4'd2, 24'h001000);
    press_recall(4'd0, 24'h000123);

    // Fill all 16 slots, 17th press ignored
    do_clr();
    check("clr_rec_valid", 32'(rec_valid), 0);
    check("clr_count", 32'(lap_count), 0);
    for (int i = 0; i < 17; i++) begin
      logic [23:0] v;
      v = 24'h050000 | 24'((i / 10) << 4) | 24'(i % 10);
      press_lap(v, i < 16, 4'(i));
      if (i == 14) check("full_at_15", 32'(full), 0);
      if (i == 15) check("full_at_16", 32'(full), 1);
    end
    check("count_16", 32'(lap_count), 16);
    check("full_after_17", 32'(full), 1);

    // Simultaneous lap and recall: lap wins and invalidates the recalled view
    do_clr();
    check("clr_full", 32'(full), 0);
    press_lap(24'h000777, 1'b1, 4'd0);
    press_lap(24'h000888, 1'b1, 4'd1);
    press_recall(4'd0, 24'h000777);
    @(negedge clk);
    dispbuf = 24'h000999;
    key_lap = 1'b1;
    key_recall = 1'b1;
    wq.push_back({4'd2, 24'h000999});
    repeat (3) @(negedge clk);
    key_lap = 1'b0;
    key_recall = 1'b0;
    repeat (6) @(negedge clk);
    check("simul_rec_valid", 32'(rec_valid), 0);
    check("simul_count", 32'(lap_count), 3);

    // Recall with no laps stored is ignored
    do_clr();
    @(negedge clk);
    key_recall = 1'b1;
    repeat (3) @(negedge clk);
    key_recall = 1'b0;
    repeat (4) @(negedge clk);
    check("empty_rcl_valid", 32'(rec_valid), 0);
    check("empty_rcl_addr", 32'(ram_addr), 2);

    // clr during READ_WAIT aborts the read
    press_lap(24'h000042, 1'b1, 4'd0);
    @(negedge clk);
    key_recall = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_addr", 32'(ram_addr), 0);
    clr = 1'b1;
    key_recall = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    check("abort_count", 32'(lap_count), 0);
    repeat (4) @(negedge clk);
    check("abort_rec_valid", 32'(rec_valid), 0);
    press_lap(24'h000055, 1'b1, 4'd0);
    check("after_abort_count", 32'(lap_count), 1);

    // Asynchronous reset in the middle of a write
    @(negedge clk);
    dispbuf = 24'h000314;
    key_lap = 1'b1;
    wq.push_back({4'd1, 24'h000314});
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_wren", 32'(ram_wren), 0);
    check("mid_rst_data", 32'(ram_data), 0);
    check("mid_rst_addr", 32'(ram_addr), 0);
    check("mid_rst_count", 32'(lap_count), 0);
    key_lap = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_count", 32'(lap_count), 0);
    check("post_rst_full", 32'(full), 0);

    check("wq_drained", 32'(wq.size()), 0);
    check("rq_drained", 32'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
